da_dct_sched: RTL and testbench
===============================

Name: da_dct_sched

Overview:
- Scheduler that shares one 4-point distributed-arithmetic DCT unit (DA_z4-type) between NREQ requesters, e.g. row/column DCT lanes.
- Accepts 4-sample jobs over valid/ready from each requester and arbitrates round-robin.
- Holds the chosen samples stable on the DA inputs, pulses start, and samples the one-cycle result after a fixed latency.
- Pushes the result and the requester id into a 2-entry output FIFO with a valid/ready handshake.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- DA_LAT, 6, cycles from the da_start cycle to the cycle in which da_result is valid; legal range 2..15.

Ports:
- sys_clk  in  1  clock; one clock domain.
- sys_rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  job request per requester.
- req_ready  out  NREQ  one-hot grant; the job transfers when valid&ready.
- req_x0  in  12*NREQ  signed sample 0; requester i uses bits [12i+11:12i].
- req_x1, req_x2, req_x3  in  12*NREQ  samples 1..3, same packing as req_x0.
- da_start  out  1  one-cycle start pulse to the DA unit.
- da_x0..da_x3  out  12 each  signed samples to the DA unit; registered and held stable from the start cycle until capture.
- da_result  in  12  signed DA output; meaningful only in the capture cycle.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accept.
- out_data  out  12  signed DCT coefficient at the FIFO head.
- out_id  out  2  requester index of out_data.

Behaviour:
Reset:
- Synchronous active-high reset, sampled at the sys_clk edge.
- Clears req_ready, da_start, da_x0..da_x3, out_valid, out_data and out_id to 0.
- FIFO emptied; state set to IDLE; round-robin pointer set to 0.
- Reset asserted mid-job aborts the job and discards any pending capture.
- The DA unit's own reset must come from the same source.

State machine:
- IDLE: if any req_valid and fifo_cnt<2, grant the first valid requester at or after rr_ptr (wrapping modulo NREQ).
  - req_ready for that requester is asserted combinationally in this cycle only.
  - Its samples are latched into da_x*; rr_ptr becomes grant+1 (mod NREQ).
  - Go to START. If no request is valid, stay in IDLE; req_ready stays 0.
- START: da_start=1 for exactly this cycle; cnt cleared to 1; go to WAIT.
- WAIT: cnt increments each cycle. When cnt==DA_LAT, write {grant_id, da_result} into the FIFO and go to IDLE.
  - da_x* are held unchanged throughout START and WAIT.
- Throughput: one job every DA_LAT+2 cycles. Only one job is ever in flight.

FIFO:
- 2 entries. A job is launched only when fifo_cnt<2 at grant. The capture write therefore never overflows and never stalls (da_result is a one-cycle pulse).
- Push and pop in the same cycle: occupancy is unchanged and data stays ordered.
- Empty: out_valid=0; out_data and out_id hold their last value.
- Full (2 entries): no grant is issued; IDLE waits.

Other rules:
- Grant and drain in the same cycle are independent.
- req_ready is never asserted outside IDLE.
- A requester dropping valid before it is granted is legal and has no effect.
- Samples pass through unmodified; widths are unchanged; no arithmetic is applied to da_result.

Optional Feature:
- Macro: DA_SCHED_STRICT_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is not implemented and is treated as 0.
- Undefined (default): round-robin as specified above.

Test Plan:
1. Single job: NREQ=2; req0 sends x0..x3=100,-50,25,7; model returns da_result=0x0A5 at start+6 -> da_start pulses once, da_x* held 7 cycles, out_valid with out_data=0x0A5, out_id=0.
2. Contention: req0 and req1 valid continuously, out_ready=1 -> out_id sequence 0,1,0,1; grants spaced DA_LAT+2=8 cycles apart.
3. Backpressure: out_ready=0, both requesters valid -> exactly 2 jobs complete, no third da_start; raise out_ready -> both entries drain in order, then granting resumes.
4. Simultaneous push/pop: FIFO holds 1 entry, out_ready=1 in the capture cycle -> occupancy stays 1, head becomes the new result, no data lost.
5. Reset mid-WAIT: assert sys_rst at cnt=3 -> next cycle all outputs 0, FIFO empty, state IDLE; the result scheduled for that job is never written.
6. With DA_SCHED_STRICT_PRIO_EN: both requesters continuously valid -> out_id always 0; req1 is granted only after req0 deasserts.

Source files
------------

// File: rtl/da_dct_sched.sv
// Round-robin scheduler that shares one 4-point DA DCT unit among NREQ requesters and queues results in a 2-entry FIFO.
// Define DA_SCHED_STRICT_PRIO_EN for fixed priority (lowest requester index wins) instead of round-robin.
module da_dct_sched #(
  parameter int NREQ   = 2,
  parameter int DA_LAT = 6
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [12*NREQ-1:0] req_x0,
  input  logic [12*NREQ-1:0] req_x1,
  input  logic [12*NREQ-1:0] req_x2,
  input  logic [12*NREQ-1:0] req_x3,
  output logic               da_start,
  output logic [11:0]        da_x0,
  output logic [11:0]        da_x1,
  output logic [11:0]        da_x2,
  output logic [11:0]        da_x3,
  input  logic [11:0]        da_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [11:0]        out_data,
  output logic [1:0]         out_id
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_e;

  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] data;
  } entry_t;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        gnt_id_q, gnt_id_d;
  logic [3:0][11:0]  x_q, x_d, sel_x;
  entry_t            head_q, head_d, tail_q, tail_d, new_e;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic              gnt_found;
  logic [1:0]        gnt_idx;
  logic              launch, capture, pop;

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
`ifdef DA_SCHED_STRICT_PRIO_EN
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = 2'(i);
      end
    end
  end
`else
  logic [1:0] rr_ptr_q, rr_ptr_d;

  // First pass covers indices at/after the pointer, second pass wraps around to the rest.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && req_valid[i] && (2'(i) >= rr_ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = 2'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (launch) rr_ptr_d = (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) rr_ptr_q <= 2'd0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    sel_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == 2'(i)) begin
        sel_x[0] = req_x0[12*i +: 12];
        sel_x[1] = req_x1[12*i +: 12];
        sel_x[2] = req_x2[12*i +: 12];
        sel_x[3] = req_x3[12*i +: 12];
      end
    end
  end

  // Launch is gated by reset so a requester never sees a transfer that reset then discards.
  assign launch  = (state_q == S_IDLE) && gnt_found && (fifo_cnt_q != 2'd2) && !sys_rst;
  assign capture = (state_q == S_WAIT) && (cnt_q == 4'(DA_LAT));
  assign pop     = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (capture) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (launch && (gnt_idx == 2'(i))) req_ready[i] = 1'b1;
    end
    da_start = (state_q == S_START);
  end

  always_comb begin
    cnt_d    = cnt_q;
    x_d      = x_q;
    gnt_id_d = gnt_id_q;
    if (launch) begin
      x_d      = sel_x;
      gnt_id_d = gnt_idx;
    end
    if (state_q == S_START)     cnt_d = 4'd1;
    else if (state_q == S_WAIT) cnt_d = cnt_q + 4'd1;
  end

  // Shift-style FIFO: the head register drives the outputs directly and keeps its value when emptied.
  always_comb begin
    new_e      = '{id: gnt_id_q, data: da_result};
    head_d     = head_q;
    tail_d     = tail_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({capture, pop})
      2'b10: begin
        if (fifo_cnt_q == 2'd0) head_d = new_e;
        else                    tail_d = new_e;
        fifo_cnt_d = fifo_cnt_q + 2'd1;
      end
      2'b01: begin
        if (fifo_cnt_q == 2'd2) head_d = tail_q;
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      2'b11: begin
        if (fifo_cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = new_e;
        end else begin
          head_d = new_e;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      gnt_id_q   <= 2'd0;
      x_q        <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fifo_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_id_q   <= gnt_id_d;
      x_q        <= x_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign da_x0     = x_q[0];
  assign da_x1     = x_q[1];
  assign da_x2     = x_q[2];
  assign da_x3     = x_q[3];
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = head_q.data;
  assign out_id    = head_q.id;

endmodule

// File: tb/tb_da_dct_sched.sv
// Self-checking bench for da_dct_sched: transaction-level reference model plus table-driven and directed sequences.
module tb_da_dct_sched;
  localparam int NREQ   = 2;
  localparam int DA_LAT = 6;
`ifdef DA_SCHED_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [12*NREQ-1:0] req_x0, req_x1, req_x2, req_x3;
  logic               da_start;
  logic [11:0]        da_x0, da_x1, da_x2, da_x3, da_result;
  logic               out_valid, out_ready;
  logic [11:0]        out_data;
  logic [1:0]         out_id;

  always #5 sys_clk = ~sys_clk;

  da_dct_sched #(.NREQ(NREQ), .DA_LAT(DA_LAT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_x1(req_x1), .req_x2(req_x2), .req_x3(req_x3),
    .da_start(da_start),
    .da_x0(da_x0), .da_x1(da_x1), .da_x2(da_x2), .da_x3(da_x3),
    .da_result(da_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: one job in flight tracked by its age in cycles since the grant.
  bit          m_init = 1'b0;
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  int          m_rr   = 0;
  int          m_id   = 0;
  logic [11:0] m_x [4];
  logic [11:0] m_res = 12'h0;
  logic [13:0] m_fifo [$];
  logic [13:0] m_shown = 14'h0;
  bit          da_fixed_en = 1'b0;
  logic [11:0] da_fixed = 12'h0;

  logic [NREQ-1:0] obs_ready;
  logic            obs_start, obs_ov;
  logic [11:0]     obs_od;
  logic [1:0]      obs_oid;
  logic [47:0]     obs_x;
  int              cyc = 0;

  function automatic logic [11:0] dct_ref(input logic [11:0] a, input logic [11:0] b,
                                          input logic [11:0] c, input logic [11:0] d);
    int s;
    s = int'($signed(a)) + 2 * int'($signed(b)) - 3 * int'($signed(c)) + int'($signed(d));
    return s[11:0];
  endfunction

  function automatic logic [11:0] samp(input logic [12*NREQ-1:0] bus, input int g);
    return bus[12*g +: 12];
  endfunction

  // One clock cycle: observe and check at the falling edge, drive the DA result, advance the model.
  task automatic tick();
    int              g;
    logic [NREQ-1:0] er;
    @(negedge sys_clk);
    cyc++;
    obs_ready = req_ready;
    obs_start = da_start;
    obs_ov    = out_valid;
    obs_od    = out_data;
    obs_oid   = out_id;
    obs_x     = {da_x0, da_x1, da_x2, da_x3};
    g  = -1;
    er = '0;
    if (m_init) begin
      if (!m_busy && m_fifo.size() < 2 && !sys_rst)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      if (g >= 0) er[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(er));
      check("da_start", 32'(da_start), 32'(m_busy && m_age == 1));
      if (m_busy && m_age >= 1) begin
        check("da_x01_hold", {8'h0, da_x0, da_x1}, {8'h0, m_x[0], m_x[1]});
        check("da_x23_hold", {8'h0, da_x2, da_x3}, {8'h0, m_x[2], m_x[3]});
      end
      check("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
      check("out_head", {18'h0, out_id, out_data}, {18'h0, m_shown});
      da_result = (m_busy && m_age == DA_LAT + 1) ? m_res : ~m_res;
    end else begin
      da_result = 12'h0;
    end
    if (sys_rst) begin
      m_init  = 1'b1;
      m_busy  = 1'b0;
      m_age   = 0;
      m_rr    = 0;
      m_shown = 14'h0;
      m_fifo.delete();
    end else if (m_init) begin
      if (m_fifo.size() != 0 && out_ready) void'(m_fifo.pop_front());
      if (m_busy) begin
        if (m_age == DA_LAT + 1) begin
          m_fifo.push_back({2'(m_id), m_res});
          m_busy = 1'b0;
        end else begin
          m_age++;
        end
      end else if (g >= 0) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_id   = g;
        m_x[0] = samp(req_x0, g);
        m_x[1] = samp(req_x1, g);
        m_x[2] = samp(req_x2, g);
        m_x[3] = samp(req_x3, g);
        m_res  = da_fixed_en ? da_fixed : dct_ref(m_x[0], m_x[1], m_x[2], m_x[3]);
        if (!STRICT) m_rr = (g + 1) % NREQ;
      end
      if (m_fifo.size() != 0) m_shown = m_fifo[0];
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic rand_samples();
    for (int i = 0; i < NREQ; i++) begin
      req_x0[12*i +: 12] = 12'($urandom);
      req_x1[12*i +: 12] = 12'($urandom);
      req_x2[12*i +: 12] = 12'($urandom);
      req_x3[12*i +: 12] = 12'($urandom);
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    out_ready = 1'b0;
    sys_rst   = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic wait_grant(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (obs_ready != '0) ok = 1'b1;
    end
    check({name, "_grant_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_out(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (obs_ov) ok = 1'b1;
    end
    check({name, "_out_seen"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [1:0]      exp_id;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [6];
    int          ids [$];
    int          gcyc [$];
    int          n;

    // Single-job table starting from a fresh reset (pointer at 0).
    tbl[0] = '{valid: 2'b01, exp_id: 2'd0};
    tbl[1] = '{valid: 2'b11, exp_id: STRICT ? 2'd0 : 2'd1};
    tbl[2] = '{valid: 2'b10, exp_id: 2'd1};
    tbl[3] = '{valid: 2'b11, exp_id: 2'd0};
    tbl[4] = '{valid: 2'b01, exp_id: 2'd0};
    tbl[5] = '{valid: 2'b11, exp_id: STRICT ? 2'd0 : 2'd1};

    req_valid = '0; out_ready = 1'b0; sys_rst = 1'b1;
    req_x0 = '0; req_x1 = '0; req_x2 = '0; req_x3 = '0; da_result = 12'h0;

    // Reset state
    do_reset();
    tick();
    check("rst_outputs", {12'h0, obs_ready, obs_start, obs_ov, obs_oid, obs_od},
          32'h0);
    check("rst_da_x", 32'(obs_x != 48'h0), 32'd0);

    // Test 1: single job with a fixed DA answer
    da_fixed_en = 1'b1;
    da_fixed    = 12'h0A5;
    out_ready   = 1'b1;
    req_x0[11:0] = 12'd100;
    req_x1[11:0] = 12'hFCE;   // -50
    req_x2[11:0] = 12'd25;
    req_x3[11:0] = 12'd7;
    req_valid = 2'b01;
    tick();
    check("t1_grant", 32'(obs_ready), 32'h1);
    req_valid = '0;
    n = 0;
    for (int k = 1; k <= DA_LAT + 1; k++) begin
      tick();
      n += int'(obs_start);
      check("t1_x_held", 32'(obs_x == {12'd100, 12'hFCE, 12'd25, 12'd7}), 32'd1);
    end
    tick();
    check("t1_out_valid", 32'(obs_ov), 32'd1);
    check("t1_out_data", 32'(obs_od), 32'h0A5);
    check("t1_out_id", 32'(obs_oid), 32'd0);
    check("t1_start_pulses", n, 1);
    da_fixed_en = 1'b0;

    // Table-driven single jobs
    do_reset();
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      rand_samples();
      req_valid = tbl[i].valid;
      wait_grant("tbl", 20);
      check("tbl_gnt", 32'(obs_ready), 32'(1 << tbl[i].exp_id));
      req_valid = '0;
      wait_out("tbl", 20);
      check("tbl_id", 32'(obs_oid), 32'(tbl[i].exp_id));
    end

`ifndef DA_SCHED_STRICT_PRIO_EN
    // Test 2: contention alternates and grants are DA_LAT+2 apart
    do_reset();
    out_ready = 1'b1;
    rand_samples();
    req_valid = 2'b11;
    for (int i = 0; i < 60 && ids.size() < 4; i++) begin
      tick();
      if (obs_ready != '0) gcyc.push_back(cyc);
      if (obs_ov) ids.push_back(int'(obs_oid));
    end
    req_valid = '0;
    check("t2_count", ids.size(), 4);
    foreach (ids[i]) check("t2_id", ids[i], i % 2);
    for (int i = 0; i + 1 < gcyc.size() && i < 3; i++)
      check("t2_spacing", gcyc[i+1] - gcyc[i], DA_LAT + 2);
`endif

    // Test 3: backpressure stops after two jobs, drains in order, then resumes
    do_reset();
    rand_samples();
    req_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n += int'(obs_start);
    end
    check("t3_starts", n, 2);
    check("t3_full_valid", 32'(obs_ov), 32'd1);
    out_ready = 1'b1;
    tick();
    check("t3_drain0", {30'h0, obs_oid}, 32'd0);
    tick();
    check("t3_drain1", {31'h0, obs_ov}, 32'd1);
    check("t3_drain1_id", {30'h0, obs_oid}, STRICT ? 32'd0 : 32'd1);
    check("t3_resume", 32'(obs_ready), 32'h1);
    req_valid = '0;
    for (int i = 0; i < DA_LAT + 4; i++) tick();

    // Test 4: push and pop in the same cycle with one entry queued
    do_reset();
    rand_samples();
    req_valid = 2'b01;
    wait_grant("t4a", 10);
    req_valid = '0;
    wait_out("t4a", 20);
    req_valid = 2'b10;
    wait_grant("t4b", 10);
    req_valid = '0;
    for (int k = 0; k < DA_LAT; k++) tick();
    out_ready = 1'b1;
    tick();
    check("t4_capture_head", {29'h0, obs_ov, obs_oid}, {29'h0, 1'b1, 2'd0});
    out_ready = 1'b0;
    tick();
    check("t4_new_head", {29'h0, obs_ov, obs_oid}, {29'h0, 1'b1, 2'd1});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("t4_empty_after", 32'(obs_ov), 32'd0);

    // Test 5: reset during WAIT (counter at 3) discards the job and clears the FIFO
    do_reset();
    rand_samples();
    req_x0[11:0] = 12'h123;
    req_x1[11:0] = 12'h456;
    req_x2[11:0] = 12'h789;
    req_x3[11:0] = 12'h3AB;
    req_valid = 2'b01;
    wait_grant("t5a", 10);
    req_valid = '0;
    wait_out("t5a", 20);
    req_valid = 2'b01;
    wait_grant("t5b", 10);
    req_valid = '0;
    for (int k = 0; k < 3; k++) tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    tick();
    check("t5_ctrl_zero", {12'h0, obs_ready, obs_start, obs_ov, obs_oid, obs_od}, 32'h0);
    check("t5_da_x_zero", 32'(obs_x != 48'h0), 32'd0);
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 2 * DA_LAT; i++) begin
      tick();
      n += int'(obs_ov);
    end
    check("t5_no_result", n, 0);

`ifdef DA_SCHED_STRICT_PRIO_EN
    // Test 6: fixed priority keeps serving requester 0
    do_reset();
    out_ready = 1'b1;
    rand_samples();
    req_valid = 2'b11;
    ids.delete();
    for (int i = 0; i < 60 && ids.size() < 3; i++) begin
      tick();
      if (obs_ov) ids.push_back(int'(obs_oid));
    end
    check("t6_count", ids.size(), 3);
    foreach (ids[i]) check("t6_id", ids[i], 0);
    req_valid = 2'b10;
    wait_out("t6", 40);
    check("t6_req1", {30'h0, obs_oid}, 32'd1);
    req_valid = '0;
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rand_samples();
      req_valid = NREQ'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      sys_rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    sys_rst = 1'b0;
    req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
